// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : Reservation-station array feeding issue. Dispatch allocates
//               one entry per cycle, the CDB wakes waiting operands, and issue
//               frees its selected entry. Optional macro RS_DUAL_CDB_EN adds
//               a second CDB port.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef RS_SIZE
`define RS_SIZE 16
`endif

package rs_pkg;
    typedef logic [31:0] MemoryWord;

    typedef struct packed {
        logic       busy;
        int         id;
        logic [7:0] op;
        int         tag_1;
        MemoryWord  value_1;
        int         tag_2;
        MemoryWord  value_2;
    } rs_entry;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int RS_SIZE = `RS_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_valid,
    input  rs_entry                    dispatch_entry,
    output logic                       dispatch_ready,
    input  logic                       cdb_valid,
    input  int                         cdb_tag,
    input  MemoryWord                  cdb_value,
`ifdef RS_DUAL_CDB_EN
    input  logic                       cdb1_valid,
    input  int                         cdb1_tag,
    input  MemoryWord                  cdb1_value,
`endif
    input  logic                       issue_valid,
    input  int                         issue_rs_id,
    input  logic                       flush,
    output rs_entry                    res_stations [RS_SIZE],
    output logic [$clog2(RS_SIZE):0]   rs_count
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    rs_entry            rs_q [RS_SIZE];
    rs_entry            rs_d [RS_SIZE];
    rs_entry            w_rs_reset [RS_SIZE];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic               w_alloc;
    logic               w_free;

    logic               w_cdb1_valid;
    int                 w_cdb1_tag;
    MemoryWord          w_cdb1_value;

`ifdef RS_DUAL_CDB_EN
    assign w_cdb1_valid = cdb1_valid;
    assign w_cdb1_tag   = cdb1_tag;
    assign w_cdb1_value = cdb1_value;
`else
    assign w_cdb1_valid = 1'b0;
    assign w_cdb1_tag   = 0;
    assign w_cdb1_value = '0;
`endif

    function automatic logic tag_hit(input logic v, input int cdb_t, input int t);
        return v && (cdb_t != 0) && (t == cdb_t);
    endfunction

    // Port 0 is checked first so it wins when both ports carry the same tag.
    function automatic rs_entry wake(
        input rs_entry   e,
        input logic      v0,
        input int        t0,
        input MemoryWord d0,
        input logic      v1,
        input int        t1,
        input MemoryWord d1
    );
        rs_entry r;
        r = e;
        if (tag_hit(v0, t0, e.tag_1)) begin
            r.tag_1   = 0;
            r.value_1 = d0;
        end else if (tag_hit(v1, t1, e.tag_1)) begin
            r.tag_1   = 0;
            r.value_1 = d1;
        end
        if (tag_hit(v0, t0, e.tag_2)) begin
            r.tag_2   = 0;
            r.value_2 = d0;
        end else if (tag_hit(v1, t1, e.tag_2)) begin
            r.tag_2   = 0;
            r.value_2 = d1;
        end
        return r;
    endfunction

    assign dispatch_ready = (count_q != CNT_W'(RS_SIZE));

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_rs_reset[i]    = '0;
            w_rs_reset[i].id = i;
        end
    end

    always_comb begin
        rs_d        = rs_q;
        count_d     = count_q;
        w_alloc     = 1'b0;
        w_free      = 1'b0;
        w_alloc_idx = '0;

        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!rs_q[i].busy) begin
                w_alloc_idx = IDX_W'(i);
            end
        end

        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_d[i].busy = 1'b0;
            end
            count_d = '0;
        end else begin
            // A freed entry skips wakeup so its fields stay exactly as they were.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].busy) begin
                    if (issue_valid && (rs_q[i].id == issue_rs_id)) begin
                        rs_d[i].busy = 1'b0;
                        w_free       = 1'b1;
                    end else begin
                        rs_d[i] = wake(rs_q[i], cdb_valid, cdb_tag, cdb_value,
                                       w_cdb1_valid, w_cdb1_tag, w_cdb1_value);
                    end
                end
            end

            if (dispatch_valid && dispatch_ready) begin
                w_alloc                = 1'b1;
                rs_d[w_alloc_idx]      = wake(dispatch_entry, cdb_valid, cdb_tag, cdb_value,
                                              w_cdb1_valid, w_cdb1_tag, w_cdb1_value);
                rs_d[w_alloc_idx].busy = 1'b1;
                rs_d[w_alloc_idx].id   = rs_q[w_alloc_idx].id;
            end

            count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_free);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q    <= w_rs_reset;
            count_q <= '0;
        end else begin
            rs_q    <= rs_d;
            count_q <= count_d;
        end
    end

    assign res_stations = rs_q;
    assign rs_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservation_station
// Description : Randomized bench for reservation_station with an array-level
//               reference model, plus directed scenarios with literal values.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_reservation_station;
    import rs_pkg::*;

    localparam int RS_SIZE = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    rs_entry    dispatch_entry;
    logic       dispatch_ready;
    logic       cdb_valid;
    int         cdb_tag;
    MemoryWord  cdb_value;
    logic       cdb1_valid;
    int         cdb1_tag;
    MemoryWord  cdb1_value;
    logic       issue_valid;
    int         issue_rs_id;
    logic       flush;
    rs_entry    res_stations [RS_SIZE];
    logic [$clog2(RS_SIZE):0] rs_count;

    int         vectors     = 0;
    int         miscompares = 0;
    logic       check_en    = 1'b0;
    rs_entry    m [RS_SIZE];

    reservation_station #(.RS_SIZE(RS_SIZE)) dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_entry (dispatch_entry),
        .dispatch_ready (dispatch_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
`ifdef RS_DUAL_CDB_EN
        .cdb1_valid     (cdb1_valid),
        .cdb1_tag       (cdb1_tag),
        .cdb1_value     (cdb1_value),
`endif
        .issue_valid    (issue_valid),
        .issue_rs_id    (issue_rs_id),
        .flush          (flush),
        .res_stations   (res_stations),
        .rs_count       (rs_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic logic hit(input logic v, input int ct, input int t);
        return v && (ct != 0) && (t == ct);
    endfunction

    // Resolve both operands against the broadcasts visible this cycle.
    function automatic rs_entry snoop(input rs_entry e);
        rs_entry r = e;
        if (hit(cdb_valid, cdb_tag, e.tag_1)) begin r.tag_1 = 0; r.value_1 = cdb_value; end
        else if (hit(cdb1_valid, cdb1_tag, e.tag_1)) begin r.tag_1 = 0; r.value_1 = cdb1_value; end
        if (hit(cdb_valid, cdb_tag, e.tag_2)) begin r.tag_2 = 0; r.value_2 = cdb_value; end
        else if (hit(cdb1_valid, cdb1_tag, e.tag_2)) begin r.tag_2 = 0; r.value_2 = cdb1_value; end
        return r;
    endfunction

    task automatic model_edge();
        rs_entry nxt [RS_SIZE];
        int      slot;
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin m[i] = '0; m[i].id = i; end
            return;
        end
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            return;
        end
        slot = -1;
        for (int i = RS_SIZE - 1; i >= 0; i--) if (!m[i].busy) slot = i;
        nxt = m;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m[i].busy) begin
                if (issue_valid && issue_rs_id == i) nxt[i].busy = 1'b0;
                else                                 nxt[i] = snoop(m[i]);
            end
        end
        if (dispatch_valid && busy_count() < RS_SIZE) begin
            nxt[slot]      = snoop(dispatch_entry);
            nxt[slot].busy = 1'b1;
            nxt[slot].id   = slot;
        end
        m = nxt;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("rs_count", 64'(rs_count), 64'(busy_count()));
            chk("dispatch_ready", 64'(dispatch_ready), 64'(busy_count() != RS_SIZE));
            for (int i = 0; i < RS_SIZE; i++) begin
                vectors++;
                if (res_stations[i] !== m[i]) begin
                    miscompares++;
                    if (miscompares <= 30)
                        $display("FAIL entry[%0d]: got %h expected %h", i, res_stations[i], m[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset          = 1'b0;
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_entry = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = 0;
        cdb_value      = '0;
        cdb1_valid     = 1'b0;
        cdb1_tag       = 0;
        cdb1_value     = '0;
        issue_valid    = 1'b0;
        issue_rs_id    = 0;
    endtask

    task automatic set_entry(input logic [7:0] op, input int t1, input int t2);
        dispatch_entry         = '0;
        dispatch_entry.busy    = 1'b0;
        dispatch_entry.id      = 99;
        dispatch_entry.op      = op;
        dispatch_entry.tag_1   = t1;
        dispatch_entry.value_1 = 32'hAAAA_0000 | 32'(op);
        dispatch_entry.tag_2   = t2;
        dispatch_entry.value_2 = 32'h5555_0000 | 32'(op);
        dispatch_valid         = 1'b1;
    endtask

    task automatic disp(input logic [7:0] op, input int t1, input int t2);
        set_entry(op, t1, t2);
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        idle();
        check_en = 1'b1;

        chk("reset_count", 64'(rs_count), 64'd0);
        chk("reset_ready", 64'(dispatch_ready), 64'd1);
        chk("reset_id5", 64'(res_stations[5].id), 64'd5);

        disp(8'd1, 0, 0);
        disp(8'd2, 0, 0);
        disp(8'd3, 9, 0);
        chk("alloc_busy0", 64'(res_stations[0].busy), 64'd1);
        chk("alloc_busy2", 64'(res_stations[2].busy), 64'd1);
        chk("alloc_id2", 64'(res_stations[2].id), 64'd2);
        chk("alloc_count3", 64'(rs_count), 64'd3);
        chk("alloc_ready", 64'(dispatch_ready), 64'd1);

        disp(8'd4, 5, 0);
        chk("wait_tag1", 64'(res_stations[3].tag_1), 64'd5);
        cdb_valid = 1'b1; cdb_tag = 5; cdb_value = 32'h1234;
        step();
        idle();
        chk("wake_value1", 64'(res_stations[3].value_1), 64'h1234);
        chk("wake_tag1", 64'(res_stations[3].tag_1), 64'd0);

        set_entry(8'd5, 0, 7);
        cdb_valid = 1'b1; cdb_tag = 7; cdb_value = 32'hBEEF;
        step();
        idle();
        chk("bypass_value2", 64'(res_stations[4].value_2), 64'hBEEF);
        chk("bypass_tag2", 64'(res_stations[4].tag_2), 64'd0);

        for (int k = 5; k < RS_SIZE; k++) disp(8'(k + 1), 0, 0);
        chk("full_count", 64'(rs_count), 64'd16);
        chk("full_ready", 64'(dispatch_ready), 64'd0);
        disp(8'h77, 0, 0);
        chk("drop_count", 64'(rs_count), 64'd16);
        chk("drop_op0", 64'(res_stations[0].op), 64'd1);

        set_entry(8'h44, 0, 0);
        issue_valid = 1'b1; issue_rs_id = 4;
        step();
        idle();
        chk("issue4_busy", 64'(res_stations[4].busy), 64'd0);
        chk("issue4_stale_op", 64'(res_stations[4].op), 64'd5);
        chk("issue4_count", 64'(rs_count), 64'd15);
        disp(8'h44, 0, 0);
        chk("refill4_op", 64'(res_stations[4].op), 64'h44);
        chk("refill4_count", 64'(rs_count), 64'd16);

        issue_valid = 1'b1; issue_rs_id = 2;
        cdb_valid = 1'b1; cdb_tag = 9; cdb_value = 32'h9999;
        step();
        idle();
        chk("freewin_busy", 64'(res_stations[2].busy), 64'd0);
        chk("freewin_tag1", 64'(res_stations[2].tag_1), 64'd9);
        chk("freewin_count", 64'(rs_count), 64'd15);

        reset = 1'b1;
        step();
        idle();
        for (int k = 0; k < 10; k++) disp(8'(k + 32), 0, 0);
        chk("pre_flush_count", 64'(rs_count), 64'd10);
        set_entry(8'h66, 0, 0);
        flush = 1'b1;
        step();
        idle();
        chk("flush_count", 64'(rs_count), 64'd0);
        chk("flush_busy0", 64'(res_stations[0].busy), 64'd0);
        chk("flush_busy10", 64'(res_stations[10].busy), 64'd0);

        for (int k = 0; k < 5; k++) disp(8'(k + 64), 0, 0);
        set_entry(8'h99, 0, 0);
        reset = 1'b1;
        step();
        idle();
        chk("midreset_count", 64'(rs_count), 64'd0);
        chk("midreset_id3", 64'(res_stations[3].id), 64'd3);
        chk("midreset_op3", 64'(res_stations[3].op), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            flush          = ($urandom_range(0, 39) == 0);
            dispatch_valid = ($urandom_range(0, 99) < 65);
            dispatch_entry.busy    = 1'($urandom_range(0, 1));
            dispatch_entry.id      = int'($urandom_range(0, 31));
            dispatch_entry.op      = 8'($urandom);
            dispatch_entry.tag_1   = int'($urandom_range(0, 7));
            dispatch_entry.value_1 = $urandom;
            dispatch_entry.tag_2   = int'($urandom_range(0, 7));
            dispatch_entry.value_2 = $urandom;
            cdb_valid   = 1'($urandom_range(0, 1));
            cdb_tag     = int'($urandom_range(0, 7));
            cdb_value   = $urandom;
`ifdef RS_DUAL_CDB_EN
            cdb1_valid  = 1'($urandom_range(0, 1));
            cdb1_tag    = int'($urandom_range(0, 7));
            cdb1_value  = $urandom;
`endif
            issue_valid = ($urandom_range(0, 99) < 45);
            issue_rs_id = int'($urandom_range(0, RS_SIZE - 1));
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
